// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core's fetch port. The word array is preloaded from a
// little-endian byte stream, and the core is held in reset until the image is complete.
module inst_rom_loader #(
    parameter int          DEPTH    = 1024,
    parameter int          AW       = 10,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce_i,
    input  logic [31:0]   addr_i,
    output logic [31:0]   inst_o,
    input  logic          ld_valid_i,
    input  logic [7:0]    ld_byte_i,
    input  logic          ld_last_i,
    output logic          ld_ready_o,
    input  logic          reload_i,
    output logic          core_rst_o,
    output logic [AW:0]   words_o,
    output logic          load_err_o
);

    typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [AW:0] r_waddr;
    logic [1:0]  r_lane;
    logic [31:0] r_word;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_full;
    logic        w_wr;
    logic [31:0] w_wdata;
    logic        w_unused_addr;

    assign w_accept = ld_valid_i & ld_ready_o;
    assign w_full   = (r_waddr == (AW+1)'(DEPTH));
    // Unfilled upper lanes stay zero because r_word is cleared after every write.
    assign w_wdata  = r_word | ({24'h0, ld_byte_i} << {r_lane, 3'b000});
    assign w_wr     = w_accept & ~w_full & ((r_lane == 2'd3) | ld_last_i);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_accept && ld_last_i) w_next = S_RUN;
            S_RUN:   if (reload_i)              w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_comb begin
        ld_ready_o = 1'b0;
        core_rst_o = 1'b0;
        if (r_state == S_LOAD) begin
            ld_ready_o = 1'b1;
            core_rst_o = 1'b1;
        end
    end

    // The write address doubles as the word count: both advance and saturate together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waddr <= '0;
            r_lane  <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else if (r_state == S_RUN && reload_i) begin
            r_waddr <= '0;
            r_lane  <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            if (w_full) begin
                r_err <= 1'b1;
            end else if (w_wr) begin
                r_waddr <= r_waddr + 1'b1;
                r_lane  <= '0;
                r_word  <= '0;
            end else begin
                r_word <= w_wdata;
                r_lane <= r_lane + 1'b1;
            end
        end
    end

    // NOTE: the word array has no reset so it maps onto plain RAM; its contents
    // survive both rst and reload.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_waddr[AW-1:0]] <= w_wdata;
        end
    end

    always_comb begin
        inst_o = 32'h0;
        if (ce_i) begin
            if (addr_i[31:AW+2] == '0) begin
                inst_o = r_mem[addr_i[AW+1:2]];
            end else begin
                inst_o = NOP_WORD;
            end
        end
    end

    assign w_unused_addr = ^addr_i[1:0];
    assign words_o       = r_waddr;
    assign load_err_o    = r_err;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader at DEPTH=4: loading, partial words,
// overflow, fetch decoding, reload and asynchronous reset.
module tb_inst_rom_loader;

    localparam int          DEPTH = 4;
    localparam int          AW    = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] inst;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        reload = 1'b0;
    logic        core_rst;
    logic [AW:0] words;
    logic        load_err;

    inst_rom_loader #(.DEPTH(DEPTH), .AW(AW), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce),
        .addr_i     (addr),
        .inst_o     (inst),
        .ld_valid_i (ld_valid),
        .ld_byte_i  (ld_byte),
        .ld_last_i  (ld_last),
        .ld_ready_o (ld_ready),
        .reload_i   (reload),
        .core_rst_o (core_rst),
        .words_o    (words),
        .load_err_o (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the loaded image.
    logic [31:0] m_mem [DEPTH];
    int          m_words;
    int          m_nbytes;
    logic        m_err;
    logic [31:0] exp_q [$];
    logic [7:0]  img [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_words  = 0;
        m_nbytes = 0;
        m_err    = 1'b0;
    endtask

    // Byte k of the image lands in word k/4, lane k%4; words past DEPTH are dropped.
    task automatic model_byte(input logic [7:0] b, input logic last);
        int w;
        int l;
        w = m_nbytes / 4;
        l = m_nbytes % 4;
        m_nbytes++;
        if (w >= DEPTH) begin
            m_err = 1'b1;
        end else begin
            if (l == 0) m_mem[w] = 32'h0;
            m_mem[w][8*l +: 8] = b;
            if (l == 3 || last) m_words = w + 1;
        end
    endtask

    task automatic send_bytes(input int n, input logic with_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_byte  = img[i];
            ld_last  = with_last && (i == n - 1);
            @(posedge clk);
            model_byte(img[i], ld_last);
        end
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic load_image(input int n);
        send_bytes(n, 1'b1);
        check("core_rst_after_last", {31'h0, core_rst}, 32'h0);
        check("ready_after_last", {31'h0, ld_ready}, 32'h0);
        check("words", {29'h0, words}, 32'(m_words));
        check("load_err", {31'h0, load_err}, {31'h0, m_err});
    endtask

    task automatic fetch(input logic c, input logic [31:0] a);
        logic [31:0] e;
        @(negedge clk);
        ce   = c;
        addr = a;
        if (!c)                e = 32'h0;
        else if (a[31:2] < 30'(DEPTH)) e = m_mem[a[AW+1:2]];
        else                   e = NOP;
        exp_q.push_back(e);
        #1;
        check($sformatf("fetch ce=%0b a=%h", c, a), inst, exp_q.pop_front());
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload   = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'hEE;
        @(posedge clk);
        #1;
        reload   = 1'b0;
        ld_valid = 1'b0;
        model_clear();
        check("reload_core_rst", {31'h0, core_rst}, 32'h1);
        check("reload_ready", {31'h0, ld_ready}, 32'h1);
        check("reload_words", {29'h0, words}, 32'h0);
        check("reload_err", {31'h0, load_err}, 32'h0);
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst", {31'h0, core_rst}, 32'h1);
        check("rst_ready", {31'h0, ld_ready}, 32'h1);
        check("rst_words", {29'h0, words}, 32'h0);
        check("rst_err", {31'h0, load_err}, 32'h0);
        check("rst_inst_ce0", inst, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Two-word program.
        {img[0], img[1], img[2], img[3], img[4], img[5], img[6], img[7]} =
            64'h13_05_10_00_93_05_20_00;
        load_image(8);
        check("prog_word0", m_mem[0], 32'h0010_0513);
        fetch(1'b1, 32'h0);
        fetch(1'b1, 32'h4);
        check("fetch4_const", inst, 32'h0020_0593);

        // Partial final word is zero-filled.
        do_reload();
        {img[0], img[1], img[2], img[3], img[4], img[5]} = 48'hAA_BB_CC_DD_11_22;
        load_image(6);
        fetch(1'b1, 32'h0);
        fetch(1'b1, 32'h4);
        check("partial_word1", inst, 32'h0000_2211);

        // Overflow: 20 bytes into a 4-word array.
        do_reload();
        for (int i = 0; i < 20; i++) img[i] = 8'(8'h40 + i);
        load_image(20);
        check("ovf_err_const", {31'h0, load_err}, 32'h1);
        check("ovf_words_const", {29'h0, words}, 32'd4);
        for (int a = 0; a < 4; a++) fetch(1'b1, 32'(4 * a));
        fetch(1'b1, 32'hC);
        check("ovf_word3", inst, 32'h4F4E_4D4C);

        // Fetch decoding in RUN.
        fetch(1'b0, 32'h4);
        fetch(1'b1, 32'(4 * DEPTH));
        fetch(1'b1, 32'hFFFF_FFFC);
        fetch(1'b1, 32'h5);
        fetch(1'b1, 32'hB);

        // Reload with a byte presented during the reload cycle; it must be dropped.
        do_reload();
        {img[0], img[1], img[2], img[3]} = 32'h01_02_03_04;
        load_image(4);
        fetch(1'b1, 32'h0);
        check("reload_word0", inst, 32'h0403_0201);

        // Asynchronous reset after one full word and three bytes of the next.
        do_reload();
        for (int i = 0; i < 7; i++) img[i] = 8'(8'h80 + i);
        send_bytes(7, 1'b0);
        check("preabort_words", {29'h0, words}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check("abort_words", {29'h0, words}, 32'h0);
        check("abort_core_rst", {31'h0, core_rst}, 32'h1);
        check("abort_ready", {31'h0, ld_ready}, 32'h1);
        check("abort_err", {31'h0, load_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        {img[0], img[1], img[2], img[3], img[4]} = 40'h5A_6B_7C_8D_9E;
        load_image(5);
        fetch(1'b1, 32'h0);
        fetch(1'b1, 32'h4);
        check("fresh_word1", inst, 32'h0000_009E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
